// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax sequencer: default sizes, FSM encoding, counter sizing.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package argmax_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int IDX_WIDTH_DEF   = 4;
  localparam int ADDR_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The read counter must hold NUM_CLASSES itself, which marks "all reads issued".
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/argmax_track_max.sv
// Running signed maximum and its index; max_val/max_idx already include the score presented now.
// Latency: registers update on the edge after a valid score; outputs reflect it combinationally.
// Backpressure: none, accepts one score per cycle whenever valid is high.
module argmax_track_max
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         first,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] score,
  input  logic        [IDX_WIDTH-1:0]  index,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic        [IDX_WIDTH-1:0]  max_idx
);

  logic signed [DATA_WIDTH-1:0] max_q;
  logic        [IDX_WIDTH-1:0]  idx_q;
  logic                         take;

  // Strictly-greater signed compare keeps the lower index on ties; the first score always loads.
  always_comb begin
    take    = valid && (first || (score > max_q));
    max_val = take ? score : max_q;
    max_idx = take ? index : idx_q;
  end

  // Hold the running winner between scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (take) begin
      max_q <= score;
      idx_q <= index;
    end
  end

endmodule

// File: rtl/argmax_sequencer.sv
// Scans NUM_CLASSES signed scores one per cycle from a buffer and returns the argmax.
// Latency: start accepted at edge T -> reads on edges T+1..T+N, result_valid at edge T+N+2.
// Backpressure: result held in DONE until result_ready; start ignored outside IDLE.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  score_rd_en,
  output logic [ADDR_WIDTH-1:0] score_rd_addr,
  input  logic [DATA_WIDTH-1:0] score_rd_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [IDX_WIDTH-1:0]  predicted_digit,
  output logic [DATA_WIDTH-1:0] max_score
);

  localparam int               CNT_W   = cnt_width(NUM_CLASSES);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_CLASSES);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [IDX_WIDTH-1:0]         rd_idx;
  logic                         d_vld;
  logic [IDX_WIDTH-1:0]         d_idx;
  logic [ADDR_WIDTH-1:0]        issue_addr;
  logic                         trk_first;
  logic signed [DATA_WIDTH-1:0] trk_val;
  logic [IDX_WIDTH-1:0]         trk_idx;

  // Address of the class about to be read, and first-score detection on the returning data.
  always_comb begin
    issue_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt);
    trk_first  = d_vld && (d_idx == '0);
  end

  // Control FSM; all outputs are registered. cnt==CNT_END means every read has been issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      rd_idx          <= '0;
      busy            <= 1'b0;
      score_rd_en     <= 1'b0;
      score_rd_addr   <= '0;
      result_valid    <= 1'b0;
      predicted_digit <= '0;
      max_score       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (cnt == CNT_END) begin
            score_rd_en   <= 1'b0;
            score_rd_addr <= '0;
            state         <= S_DRAIN;
          end else begin
            score_rd_en   <= 1'b1;
            score_rd_addr <= issue_addr;
            rd_idx        <= IDX_WIDTH'(cnt);
            cnt           <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // The tracker outputs already fold in the last score returning this cycle.
          state           <= S_DONE;
          result_valid    <= 1'b1;
          predicted_digit <= trk_idx;
          max_score       <= trk_val;
        end
        S_DONE: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay the read strobe and its class index to line up with the buffer's one-cycle read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_vld <= 1'b0;
      d_idx <= '0;
    end else begin
      d_vld <= score_rd_en;
      d_idx <= rd_idx;
    end
  end

  argmax_track_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_track (
    .clk     (clk),
    .rst     (rst),
    .first   (trk_first),
    .valid   (d_vld),
    .score   ($signed(score_rd_data)),
    .index   (d_idx),
    .max_val (trk_val),
    .max_idx (trk_idx)
  );

endmodule

// File: tb/tb_argmax_sequencer.sv
// Bench for argmax_sequencer: table-driven scans plus hand sequences for stall, reset and N=1.
// Latency: checks result_valid at start edge + N + 2.
// Backpressure: exercises result_ready held low with start pulses during DONE.
module tb_argmax_sequencer;

  localparam int          N       = 10;
  localparam logic [15:0] GARBAGE = 16'h7FFE;

  typedef struct packed {
    logic [0:9][15:0] sc;
    logic [3:0]       idx;
    logic [15:0]      mx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        score_rd_en;
  logic [3:0]  score_rd_addr;
  logic [15:0] score_rd_data;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [3:0]  predicted_digit;
  logic [15:0] max_score;

  logic        start_b = 1'b0;
  logic        busy_b;
  logic        rd_en_b;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        valid_b;
  logic        ready_b = 1'b1;
  logic [3:0]  pred_b;
  logic [15:0] max_b;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic        en_a, en_b;
  logic [3:0]  ad_a, ad_b;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs [4];

  argmax_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .score_rd_en     (score_rd_en),
    .score_rd_addr   (score_rd_addr),
    .score_rd_data   (score_rd_data),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .predicted_digit (predicted_digit),
    .max_score       (max_score)
  );

  argmax_sequencer #(.NUM_CLASSES(1), .BASE_ADDR(5)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .start           (start_b),
    .busy            (busy_b),
    .score_rd_en     (rd_en_b),
    .score_rd_addr   (rd_addr_b),
    .score_rd_data   (rd_data_b),
    .result_valid    (valid_b),
    .result_ready    (ready_b),
    .predicted_digit (pred_b),
    .max_score       (max_b)
  );

  always #5 clk = ~clk;

  // Score buffers: data for a strobe seen in one cycle is presented in the following cycle.
  initial begin
    score_rd_data = '0;
    forever begin
      @(negedge clk);
      en_a = score_rd_en;
      ad_a = score_rd_addr;
      @(posedge clk);
      #1 score_rd_data = en_a ? mem_a[ad_a] : GARBAGE;
    end
  end

  initial begin
    rd_data_b = '0;
    forever begin
      @(negedge clk);
      en_b = rd_en_b;
      ad_b = rd_addr_b;
      @(posedge clk);
      #1 rd_data_b = en_b ? mem_b[ad_b] : GARBAGE;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_scan(input string tag, input logic [0:9][15:0] sc, input int eidx, input int emax);
    int k_valid;
    int prev_max;
    for (int i = 0; i < N; i++) mem_a[i] = sc[i];
    prev_max = $signed(max_score);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_rd_en_at_T"}, score_rd_en, 0);
    k_valid = -1;
    for (int k = 1; k <= 20 && k_valid < 0; k++) begin
      @(posedge clk);
      #1;
      if (k <= N) begin
        check({tag, "_rd_en"}, score_rd_en, 1);
        check({tag, "_rd_addr"}, score_rd_addr, k - 1);
      end else if (k == N + 1) begin
        check({tag, "_rd_en_off"}, score_rd_en, 0);
        check({tag, "_rd_addr_off"}, score_rd_addr, 0);
        check({tag, "_max_held_in_drain"}, $signed(max_score), prev_max);
      end
      if (result_valid) k_valid = k;
    end
    check({tag, "_valid_latency"}, k_valid, N + 2);
    check({tag, "_predicted"}, predicted_digit, eidx);
    check({tag, "_max"}, $signed(max_score), emax);
    @(posedge clk);
    #1;
    check({tag, "_valid_after_hs"}, result_valid, 0);
    check({tag, "_busy_after_hs"}, busy, 0);
    check({tag, "_predicted_kept"}, predicted_digit, eidx);
  endtask

  initial begin
    int k_valid;
    int bad;
    int reads;

    vecs[0] = '{sc: {16'sd3, -16'sd1, 16'sd7, 16'sd2, 16'sd0, 16'sd5, 16'sd7, 16'sd1, -16'sd8, 16'sd4},
                idx: 4'd2, mx: 16'sd7};
    vecs[1] = '{sc: {-16'sd5, -16'sd3, -16'sd9, -16'sd3, -16'sd20, -16'sd7, -16'sd4, -16'sd6, -16'sd8, -16'sd10},
                idx: 4'd1, mx: -16'sd3};
    vecs[2] = '{sc: {{9{16'd0}}, 16'h7FFF}, idx: 4'd9, mx: 16'h7FFF};
    vecs[3] = '{sc: {10{16'h8000}}, idx: 4'd0, mx: 16'h8000};

    for (int i = 0; i < 16; i++) begin
      mem_a[i] = GARBAGE;
      mem_b[i] = GARBAGE;
    end
    mem_b[5] = 16'hFFFE;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", score_rd_en, 0);
    check("rst_rd_addr", score_rd_addr, 0);
    check("rst_valid", result_valid, 0);
    check("rst_predicted", predicted_digit, 0);
    check("rst_max", max_score, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven scans with result_ready tied high
    for (int v = 0; v < 4; v++) begin
      run_scan($sformatf("vec%0d", v), vecs[v].sc, vecs[v].idx, $signed(vecs[v].mx));
    end

    // Consumer stalls for 20 cycles while start pulses arrive
    result_ready = 1'b0;
    for (int i = 0; i < N; i++) mem_a[i] = vecs[0].sc[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k_valid = -1;
    for (int k = 1; k <= 20 && k_valid < 0; k++) begin
      @(posedge clk);
      #1;
      if (result_valid) k_valid = k;
    end
    check("stall_valid_latency", k_valid, N + 2);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = c[0];
      @(posedge clk);
      #1;
      if (!(result_valid && busy && predicted_digit == 4'd2 && max_score == 16'd7 && !score_rd_en)) bad++;
    end
    check("stall_unstable_cycles", bad, 0);
    @(negedge clk);
    start        = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_hs_valid", result_valid, 0);
    check("stall_hs_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hs_start_ignored_busy", busy, 0);
    check("hs_start_ignored_rd_en", score_rd_en, 0);

    // Reset while four reads have been issued
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_rd_en", score_rd_en, 1);
    check("pre_rst_rd_addr", score_rd_addr, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", score_rd_en, 0);
    check("midrst_rd_addr", score_rd_addr, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_predicted", predicted_digit, 0);
    check("midrst_max", max_score, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (result_valid || busy) bad++;
    end
    check("post_rst_stale_cycles", bad, 0);
    run_scan("rescan", {16'sd1, 16'sd9, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd0}, 1, 9);

    // Single-class instance at base address 5
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    reads   = 0;
    k_valid = -1;
    for (int k = 1; k <= 10 && k_valid < 0; k++) begin
      @(posedge clk);
      #1;
      if (rd_en_b) begin
        reads++;
        check("n1_rd_addr", rd_addr_b, 5);
        check("n1_read_cycle", k, 1);
      end
      if (valid_b) k_valid = k;
    end
    check("n1_read_count", reads, 1);
    check("n1_valid_latency", k_valid, 3);
    check("n1_predicted", pred_b, 0);
    check("n1_max", $signed(max_b), -2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
